uart_tx_arbiter: RTL

Shares one UART byte transmitter between `NUM_REQ` requesters. Arbitrates pending byte requests, latches the winning byte, and issues a one-cycle `tx_start_o`. It holds `tx_data_o` stable for the whole frame and counts baud ticks to detect frame completion before granting again. It sits between the per-source byte producers and the transmitter FSM, whose `data`, `tx_start` and `baud` inputs it drives or shares.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters; a frame ends after FRAME_TICKS baud ticks.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [8*NUM_REQ-1:0]       data_i,
  input  logic                       baud_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_start_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_TICKS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_req;
  logic [GW-1:0] winner;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_req = 1'b1;
        winner  = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] ptr_q, ptr_d;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    else return idx + GW'(1);
  endfunction

  // Scan offsets from the top so the smallest offset from the pointer wins.
  always_comb begin
    logic [GW-1:0] idx;
    any_req = 1'b0;
    winner  = ptr_q;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_DONE) ptr_d = next_idx(grant_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          data_d  = data_i[{winner, 3'b000} +: 8];
          state_d = S_START;
        end
      end
      // The transmitter has not left idle yet, so a baud tick here is not part of the frame.
      S_START: begin
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (baud_i) begin
          if (cnt_q == LAST_CNT) state_d = S_DONE;
          else                   cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ack_o = '0;
    if (state_q == S_START) ack_o[grant_q] = 1'b1;
    tx_start_o = (state_q == S_START);
    busy_o     = (state_q == S_START) || (state_q == S_SEND);
    done_o     = (state_q == S_DONE);
    grant_o    = grant_q;
    tx_data_o  = data_q;
  end

endmodule
